// File: rtl/element_delay_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// element_delay_accumulator_pkg
// Shared definitions for the K_n increment-term path: default geometry,
// derived widths of the K_n term and of the squared-delay residual, and the
// accumulator state encoding. The increment-term calculator takes its term
// width from here as well.
// -----------------------------------------------------------------------------
package element_delay_accumulator_pkg;

    localparam int DEF_DW_INTEGER  = 18;
    localparam int DEF_DW_FRACTION = 6;
    localparam int DEF_DW_DELAY    = 12;
    localparam int DEF_N_ELEMENTS  = 32;
    localparam int IDX_W           = 6;

    // K_n: sign + integer + fraction bits.
    function automatic int term_width(input int dw_integer, input int dw_fraction);
        return dw_integer + dw_fraction + 1;
    endfunction

    // Residual: two guard bits above K_n so a term can be added to a residual
    // that is still carrying up to one (2d+1) span without wrapping.
    function automatic int resid_width(input int dw_integer, input int dw_fraction);
        return dw_integer + dw_fraction + 3;
    endfunction

    localparam int TERM_W  = term_width(DEF_DW_INTEGER, DEF_DW_FRACTION);
    localparam int RESID_W = resid_width(DEF_DW_INTEGER, DEF_DW_FRACTION);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TERM = 2'd1,
        ST_ADJUST    = 2'd2,
        ST_OUTPUT    = 2'd3
    } acc_state_t;

endpackage

// File: rtl/element_delay_accumulator_step.sv
// -----------------------------------------------------------------------------
// delay_step_unit
// One side (+n or -n) of the delay accumulator. Holds the integer delay d and
// the residual E = (d_init^2 + sum K) - d^2 in fixed point, and walks d by one
// sample per enabled cycle so that 0 <= E < (2d+1) holds once settled.
//
// Ports
//   clk, rst     clock, asynchronous active-low reset
//   load         restart: d = d_init, E = 0 (highest priority)
//   d_init       centre-element delay
//   add_en       add the sign-extended term to E
//   term         signed K_n for this side
//   step_en      permit one square-root step this cycle
//   d            current integer delay
//   settled      no step is needed (combinational on current d/E)
//   clamped      a step this cycle hit d == 0 or d == max (one-cycle flag)
// -----------------------------------------------------------------------------
module delay_step_unit
    import element_delay_accumulator_pkg::*;
#(
    parameter int DW_DELAY    = DEF_DW_DELAY,
    parameter int DW_FRACTION = DEF_DW_FRACTION,
    parameter int TERM_W      = element_delay_accumulator_pkg::TERM_W,
    parameter int RESID_W     = element_delay_accumulator_pkg::RESID_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [DW_DELAY-1:0]       d_init,
    input  logic                      add_en,
    input  logic signed [TERM_W-1:0]  term,
    input  logic                      step_en,
    output logic [DW_DELAY-1:0]       d,
    output logic                      settled,
    output logic                      clamped
);

    localparam int PAD = RESID_W - DW_DELAY - 1;
    localparam logic [DW_DELAY-1:0] D_MAX = '1;

    logic [DW_DELAY-1:0]       d_reg, d_next;
    logic signed [RESID_W-1:0] e_reg, e_next;
    logic [DW_DELAY-1:0]       d_minus_one;
    logic signed [RESID_W-1:0] up_span, dn_span, term_ext;
    logic                      need_up, need_dn;

    // (2d+1) and (2d-1) aligned to the residual's fraction point. {d,1} is 2d+1
    // and {d-1,1} is 2d-1; the d == 0 case of the latter is never used because
    // stepping down from zero clamps instead.
    assign d_minus_one = d_reg - DW_DELAY'(1);
    assign up_span  = $signed({{PAD{1'b0}}, d_reg, 1'b1}) << DW_FRACTION;
    assign dn_span  = $signed({{PAD{1'b0}}, d_minus_one, 1'b1}) << DW_FRACTION;
    assign term_ext = {{(RESID_W-TERM_W){term[TERM_W-1]}}, term};

    assign need_up = (e_reg >= up_span);
    assign need_dn = e_reg[RESID_W-1];
    assign settled = !need_up && !need_dn;

    always_comb begin
        d_next  = d_reg;
        e_next  = e_reg;
        clamped = 1'b0;
        if (load) begin
            d_next = d_init;
            e_next = '0;
        end else if (add_en) begin
            e_next = e_reg + term_ext;
        end else if (step_en) begin
            if (need_up) begin
                if (d_reg == D_MAX) begin
                    // Zeroing E forces the side to settle at the rail.
                    e_next  = '0;
                    clamped = 1'b1;
                end else begin
                    e_next = e_reg - up_span;
                    d_next = d_reg + DW_DELAY'(1);
                end
            end else if (need_dn) begin
                if (d_reg == '0) begin
                    e_next  = '0;
                    clamped = 1'b1;
                end else begin
                    e_next = e_reg + dn_span;
                    d_next = d_minus_one;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_reg <= '0;
            e_reg <= '0;
        end else begin
            d_reg <= d_next;
            e_reg <= e_next;
        end
    end

    assign d = d_reg;

endmodule

// File: rtl/element_delay_accumulator.sv
// -----------------------------------------------------------------------------
// element_delay_accumulator
// Consumer of the K_n increment-term handshake. Each accepted term pair is
// folded into the +n and -n squared-delay residuals; two step units then walk
// their integer delays to floor(sqrt(d_init^2 + sum K)) and the pair is
// offered to the delay bank over a valid/ack handshake.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   initiate, d_init      start an acquisition with centre delay d_init (IDLE)
//   term_pos, term_neg    signed K_n for +n / -n
//   term_ready, term_ack  term handshake; ack is a one-cycle pulse
//   delay_pos, delay_neg  integer delays for element +-(n+1)
//   element_idx           n of the term behind the current output
//   delay_valid/_ack      output handshake; valid held until ack
//   done                  one-cycle pulse after the last element is acked
//   range_error           sticky clamp flag, cleared by the next initiate
// -----------------------------------------------------------------------------
module element_delay_accumulator
    import element_delay_accumulator_pkg::*;
#(
    parameter int DW_INTEGER  = DEF_DW_INTEGER,
    parameter int DW_FRACTION = DEF_DW_FRACTION,
    parameter int DW_DELAY    = DEF_DW_DELAY,
    parameter int N_ELEMENTS  = DEF_N_ELEMENTS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  initiate,
    input  logic [DW_DELAY-1:0]                   d_init,
    input  logic signed [DW_INTEGER+DW_FRACTION:0] term_pos,
    input  logic signed [DW_INTEGER+DW_FRACTION:0] term_neg,
    input  logic                                  term_ready,
    output logic                                  term_ack,
    output logic [DW_DELAY-1:0]                   delay_pos,
    output logic [DW_DELAY-1:0]                   delay_neg,
    output logic [IDX_W-1:0]                      element_idx,
    output logic                                  delay_valid,
    input  logic                                  delay_ack,
    output logic                                  done,
    output logic                                  range_error
);

    localparam int K_W = term_width(DW_INTEGER, DW_FRACTION);
    localparam int E_W = resid_width(DW_INTEGER, DW_FRACTION);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEMENTS - 1);

    acc_state_t state_reg, state_next;

    logic [IDX_W-1:0] idx_reg;
    logic             term_ack_reg, delay_valid_reg, done_reg, range_error_reg;

    logic signed [K_W-1:0]    term_side [2];
    logic [DW_DELAY-1:0]      d_side    [2];
    logic [1:0]               settled_side, clamped_side;

    logic load_en, add_en, step_en, all_settled, out_ack, is_last;

    assign load_en     = (state_reg == ST_IDLE) && initiate;
    assign add_en      = (state_reg == ST_WAIT_TERM) && term_ready;
    assign step_en     = (state_reg == ST_ADJUST);
    assign out_ack     = (state_reg == ST_OUTPUT) && delay_ack;
    assign all_settled = &settled_side;
    assign is_last     = (idx_reg == IDX_LAST);

    assign term_side[0] = term_pos;
    assign term_side[1] = term_neg;

    // Side 0 is +n, side 1 is -n; both step in lock-step on the same enables.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            delay_step_unit #(
                .DW_DELAY   (DW_DELAY),
                .DW_FRACTION(DW_FRACTION),
                .TERM_W     (K_W),
                .RESID_W    (E_W)
            ) u_step (
                .clk    (clk),
                .rst    (rst),
                .load   (load_en),
                .d_init (d_init),
                .add_en (add_en),
                .term   (term_side[gi]),
                .step_en(step_en),
                .d      (d_side[gi]),
                .settled(settled_side[gi]),
                .clamped(clamped_side[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (initiate)    state_next = ST_WAIT_TERM;
            ST_WAIT_TERM: if (term_ready)  state_next = ST_ADJUST;
            ST_ADJUST:    if (all_settled) state_next = ST_OUTPUT;
            ST_OUTPUT:    if (delay_ack)   state_next = is_last ? ST_IDLE : ST_WAIT_TERM;
            default:                       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg         <= '0;
            term_ack_reg    <= 1'b0;
            delay_valid_reg <= 1'b0;
            done_reg        <= 1'b0;
            range_error_reg <= 1'b0;
        end else begin
            term_ack_reg <= add_en;
            done_reg     <= out_ack && is_last;

            // Settledness is evaluated in the same ADJUST cycle that would
            // otherwise step, so a zero-step term goes straight to OUTPUT.
            if (step_en && all_settled) begin
                delay_valid_reg <= 1'b1;
            end else if (out_ack) begin
                delay_valid_reg <= 1'b0;
            end

            if (load_en) begin
                idx_reg <= '0;
            end else if (out_ack && !is_last) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end

            if (load_en) begin
                range_error_reg <= 1'b0;
            end else if (|clamped_side) begin
                range_error_reg <= 1'b1;
            end
        end
    end

    assign term_ack    = term_ack_reg;
    assign delay_valid = delay_valid_reg;
    assign done        = done_reg;
    assign range_error = range_error_reg;
    assign element_idx = idx_reg;
    assign delay_pos   = d_side[0];
    assign delay_neg   = d_side[1];

endmodule

// File: doc/element_delay_accumulator.md
# element_delay_accumulator

Consumer end of the K_n increment-term handshake. Takes the per-element comparator terms K_n (positive-side and negative-side pair) from the increment-term calculator, one pair per element, over the ready/ack protocol. Integrates each term into a squared-delay residual and derives integer sample delays for elements +n and −n by an iterative square-root walk. Publishes one delay pair per element to the beamformer delay bank.

## Interface
- `DW_INTEGER`, 18: integer bits of K_n.
- `DW_FRACTION`, 6: fraction bits of K_n and of the residual.
- `DW_DELAY`, 12: width of the integer delay outputs.
- `N_ELEMENTS`, 32: term pairs per acquisition.

- `clk`: in, 1, single clock, rising edge.
- `rst`: in, 1, asynchronous, active-low reset.
- `initiate`: in, 1, starts an acquisition and latches `d_init`; honoured only in IDLE.
- `d_init`: in, DW_DELAY, centre-element delay d_0 in samples.
- `term_pos`: in, signed DW_INTEGER+DW_FRACTION+1, K_n for the +n side.
- `term_neg`: in, signed DW_INTEGER+DW_FRACTION+1, K_n for the −n side.
- `term_ready`: in, 1, the term pair is valid; held until acked.
- `term_ack`: out, 1, one-cycle pulse when the pair has been latched.
- `delay_pos`, `delay_neg`: out, DW_DELAY, integer delays for element ±(n+1).
- `element_idx`: out, 6, index n of the term that produced the current output.
- `delay_valid`: out, 1, output pair valid; held until `delay_ack`.
- `delay_ack`: in, 1, downstream has consumed the output pair.
- `done`: out, 1, one-cycle pulse after the last element is acked.
- `range_error`: out, 1, sticky until the next `initiate`; set on clamping.

## Operation
- Residual E per side: signed, DW_INTEGER+DW_FRACTION+3 bits, DW_FRACTION fraction bits.
- Invariant after settling: 0 ≤ E < (2d+1), with the bound in the same fixed-point format. This makes d = floor(sqrt(d_init² + ΣK)).
- States: IDLE, WAIT_TERM, ADJUST, OUTPUT.
- **IDLE**
  - On `initiate`: d_pos = d_neg = `d_init`, E_pos = E_neg = 0, idx = 0, `range_error` cleared.
  - Next state WAIT_TERM.
- **WAIT_TERM**
  - On `term_ready`: E_pos += `term_pos`, E_neg += `term_neg` (sign-extended).
  - Register `term_ack` = 1 for exactly one cycle.
  - Next state ADJUST.
- **ADJUST**: each cycle, each side independently takes at most one step.
  - If E ≥ (2d+1)<<DW_FRACTION: E −= (2d+1)<<DW_FRACTION, d += 1.
  - Else if E < 0: E += (2d−1)<<DW_FRACTION, d −= 1.
  - When neither side needs a step: register `delay_valid` = 1 and go to OUTPUT.
- **OUTPUT**
  - On `delay_ack`: `delay_valid` = 0.
  - If idx == N_ELEMENTS−1: pulse `done` and go to IDLE.
  - Otherwise idx += 1 and go to WAIT_TERM.
- **Clamping**
  - Step down requested with d == 0: d stays 0, E = 0, `range_error` = 1.
  - Step up requested with d == 2^DW_DELAY−1: d holds, E = 0, `range_error` = 1.
  - Either case terminates stepping on that side.
- **Ignored inputs**
  - `term_ready` outside WAIT_TERM.
  - `initiate` outside IDLE.
  - `delay_ack` outside OUTPUT.

## Timing
- Reset values: all outputs 0, state IDLE, d/E/idx 0.
- Reset asserted mid-operation returns to IDLE immediately. Any pending `term_ack`/`delay_valid` drops asynchronously.
- `term_ack` is high in the cycle after the `term_ready` sampling edge T, for one cycle only. The producer deasserts `term_ready` on seeing it; no double latch is possible because the FSM has left WAIT_TERM.
- With k = max(steps_pos, steps_neg), `delay_valid` rises at edge T+1+k. Zero-step latency is 2 cycles from sampling.
- `delay_pos`, `delay_neg` and `element_idx` are stable for the whole time `delay_valid` is high.
- `done` is high in the cycle after the final `delay_ack` edge, together with the return to IDLE. `initiate` is accepted from that cycle onward.

## Structure
- Shared package holds:
  - the state enum;
  - K and residual width localparams derived from DW_INTEGER/DW_FRACTION;
  - N_ELEMENTS default.
- The package is reused by the increment-term calculator for its term width.
- One sub-module, `delay_step_unit`, is instantiated twice (pos/neg). It holds d and E, performs one clamped step per enable, and flags `settled` and `clamped`.
- The top level contains only the FSM, idx counter and handshakes.

## Test plan
- `d_init`=100, K_pos=201.0, K_neg=−199.0 → delay_pos=101, delay_neg=99; `delay_valid` at T+2; `term_ack` one cycle.
- `d_init`=100, K_pos=404.0 → delay_pos=102 after 2 steps; `delay_valid` at T+3.
- `d_init`=100, K=16.46875 on both sides → delays remain 100, E=16.46875; zero-step latency 2 cycles.
- `d_init`=0, K_neg=−1.0 → delay_neg=0, `range_error`=1, delay_pos path unaffected; `range_error` cleared by the next `initiate`.
- 32 term pairs with K=A_0(2n+1) (A_0=16.46875) and `delay_ack` delayed 3 cycles each:
  - delays must match floor(sqrt(d_init²+A_0(n+1)²)) for every element;
  - `element_idx` runs 0..31;
  - `done` pulses once and the FSM returns to IDLE.
- Reset asserted during ADJUST → all outputs 0 asynchronously; a fresh `initiate` runs a full clean sequence.
